// File: rtl/input_scratch_pad_pkg.sv
// Shared definitions for the input scratchpad and the downstream PE address
// generator: pointer width derivation and modular pointer arithmetic.
`timescale 1ns/1ps
package input_scratch_pkg;

  // Pointer/offset width for a given entry count (at least one bit).
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Advance a circular pointer. Callers guarantee ptr + inc < 2*depth, so
  // one compare-and-subtract replaces a real modulo.
  function automatic int unsigned wrap_add(input int unsigned ptr,
                                           input int unsigned inc,
                                           input int unsigned depth);
    int unsigned sum;
    sum = ptr + inc;
    return (sum >= depth) ? (sum - depth) : sum;
  endfunction

endpackage

// File: rtl/input_scratch_pad_if.sv
// Bus between the input buffer / PE side (master) and the scratchpad (slave).
`timescale 1ns/1ps
interface input_scratch_pad_if
  import input_scratch_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
);
  localparam int ADDR_WIDTH = addr_width(DEPTH);

  logic                  clear;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_offset;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  shift_en;
  logic [ADDR_WIDTH:0]   shift_amt;
  logic [ADDR_WIDTH:0]   count;
  logic                  scratch_write_en;
  logic                  err_ovf;
  logic                  err_udf;

  modport master (
    output clear, wr_en, din, rd_en, rd_offset, shift_en, shift_amt,
    input  dout, dout_valid, count, scratch_write_en, err_ovf, err_udf
  );

  modport slave (
    input  clear, wr_en, din, rd_en, rd_offset, shift_en, shift_amt,
    output dout, dout_valid, count, scratch_write_en, err_ovf, err_udf
  );

endinterface

// File: rtl/input_scratch_pad_regfile.sv
// DEPTH x DATA_WIDTH storage with one write port and one registered read port.
// The array itself is never reset so it can map onto RAM; only the read
// register is reset.
`timescale 1ns/1ps
module scratch_regfile #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; suppressed while reset is held so no partial write lands.
  always_ff @(posedge clk) begin
    if (rstn && we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value when no read is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/input_scratch_pad.sv
// Circular scratchpad behind the input buffer: in-order writes, reads at an
// offset from a sliding base, and PE-driven retirement of consumed words.
`timescale 1ns/1ps
module input_scratch_pad
  import input_scratch_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input_scratch_pad_if.slave   bus
);

  localparam int ADDR_WIDTH = addr_width(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wptr_reg, wptr_next;
  logic [ADDR_WIDTH-1:0] base_reg, base_next;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   count_reg, count_next;
  logic [ADDR_WIDTH:0]   shift_eff;
  logic                  full;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ovf_hit;
  logic                  udf_hit;
  logic                  dout_valid_reg;
  logic                  err_ovf_reg;
  logic                  err_udf_reg;

  // Accept/reject decisions and next pointer values, all from pre-update state.
  always_comb begin
    full      = (count_reg == FULL_COUNT);
    wr_acc    = bus.wr_en && !full && !bus.clear;
    ovf_hit   = bus.wr_en && full;
    udf_hit   = bus.shift_en && (bus.shift_amt > count_reg);
    shift_eff = '0;
    if (bus.shift_en) begin
      shift_eff = udf_hit ? count_reg : bus.shift_amt;
    end
    // Offsets at or beyond count address unwritten slots, including the one
    // being written this cycle, so they are refused.
    rd_acc     = bus.rd_en && ({1'b0, bus.rd_offset} < count_reg) && !bus.clear;
    rd_addr    = ADDR_WIDTH'(wrap_add(32'(base_reg), 32'(bus.rd_offset), DEPTH));
    wptr_next  = ADDR_WIDTH'(wrap_add(32'(wptr_reg), 32'(wr_acc), DEPTH));
    base_next  = ADDR_WIDTH'(wrap_add(32'(base_reg), 32'(shift_eff), DEPTH));
    count_next = count_reg + (ADDR_WIDTH+1)'(wr_acc) - shift_eff;
  end

  // Pointer, occupancy, read-valid and sticky error state; clear wins over all.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_reg       <= '0;
      base_reg       <= '0;
      count_reg      <= '0;
      dout_valid_reg <= 1'b0;
      err_ovf_reg    <= 1'b0;
      err_udf_reg    <= 1'b0;
    end else if (bus.clear) begin
      wptr_reg       <= '0;
      base_reg       <= '0;
      count_reg      <= '0;
      dout_valid_reg <= 1'b0;
      err_ovf_reg    <= 1'b0;
      err_udf_reg    <= 1'b0;
    end else begin
      wptr_reg       <= wptr_next;
      base_reg       <= base_next;
      count_reg      <= count_next;
      dout_valid_reg <= rd_acc;
      if (ovf_hit) err_ovf_reg <= 1'b1;
      if (udf_hit) err_udf_reg <= 1'b1;
    end
  end

  scratch_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regfile (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_acc),
    .waddr (wptr_reg),
    .wdata (bus.din),
    .re    (rd_acc),
    .raddr (rd_addr),
    .rdata (bus.dout)
  );

  assign bus.count            = count_reg;
  assign bus.scratch_write_en = (count_reg != FULL_COUNT);
  assign bus.dout_valid       = dout_valid_reg;
  assign bus.err_ovf          = err_ovf_reg;
  assign bus.err_udf          = err_udf_reg;

endmodule

// File: tb/tb_input_scratch_pad.sv
// Directed bench for input_scratch_pad (DATA_WIDTH=16, DEPTH=8).
`timescale 1ns/1ps
module tb_input_scratch_pad;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  input_scratch_pad_if #(.DATA_WIDTH(16), .DEPTH(8)) bus ();

  input_scratch_pad #(.DATA_WIDTH(16), .DEPTH(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.clear     = 1'b0;
    bus.wr_en     = 1'b0;
    bus.din       = '0;
    bus.rd_en     = 1'b0;
    bus.rd_offset = '0;
    bus.shift_en  = 1'b0;
    bus.shift_amt = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle();
    tick();
    tick();
    checks++;
    if (bus.count !== 4'd0 || bus.scratch_write_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_count: count=%0d swe=%0b required count=0 swe=1", bus.count, bus.scratch_write_en);
    end
    checks++;
    if (bus.dout !== 16'h0 || bus.dout_valid !== 1'b0 || bus.err_ovf !== 1'b0 || bus.err_udf !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: dout=%h dv=%0b ovf=%0b udf=%0b required 0000/0/0/0",
               bus.dout, bus.dout_valid, bus.err_ovf, bus.err_udf);
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (bus.count !== 4'd0 || bus.scratch_write_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: count=%0d swe=%0b required 0/1", bus.count, bus.scratch_write_en);
    end
  endtask

  // Read offsets first..first+n-1 back to back, expecting exp_base+k.
  task automatic read_run(input int first, input int n, input logic [15:0] exp_base, input string name);
    for (int k = 0; k < n; k++) begin
      bus.rd_en     = 1'b1;
      bus.rd_offset = 3'(first + k);
      tick();
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== exp_base + 16'(k)) begin
        errors++;
        $display("FAIL %s_off%0d: dout=%h dv=%0b required dout=%h dv=1",
                 name, first + k, bus.dout, bus.dout_valid, exp_base + 16'(k));
      end
    end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_fill_read();
    for (int i = 1; i <= 8; i++) begin
      bus.wr_en = 1'b1;
      bus.din   = 16'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    checks++;
    if (bus.count !== 4'd8 || bus.scratch_write_en !== 1'b0) begin
      errors++;
      $display("FAIL fill_count: count=%0d swe=%0b required 8/0", bus.count, bus.scratch_write_en);
    end
    read_run(0, 8, 16'h0001, "fill_read");
    tick();
    checks++;
    if (bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_dv_pulse: dv=%0b required 0", bus.dout_valid);
    end
  endtask

  task automatic test_overflow();
    bus.wr_en = 1'b1;
    bus.din   = 16'h00AA;
    tick();
    bus.wr_en = 1'b0;
    checks++;
    if (bus.err_ovf !== 1'b1 || bus.count !== 4'd8) begin
      errors++;
      $display("FAIL ovf_flag: ovf=%0b count=%0d required 1/8", bus.err_ovf, bus.count);
    end
    // Shift 3 with a write while still full: the write must be rejected.
    bus.shift_en  = 1'b1;
    bus.shift_amt = 4'd3;
    bus.wr_en     = 1'b1;
    bus.din       = 16'h0009;
    tick();
    idle();
    checks++;
    if (bus.count !== 4'd5 || bus.scratch_write_en !== 1'b1) begin
      errors++;
      $display("FAIL ovf_shift_count: count=%0d swe=%0b required 5/1", bus.count, bus.scratch_write_en);
    end
    read_run(0, 1, 16'h0004, "ovf_read");
  endtask

  task automatic test_wrap();
    // base=3, wptr=0, count=5: words 9..B land in physical entries 0..2.
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1;
      bus.din   = 16'(16'h0009 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    checks++;
    if (bus.count !== 4'd8 || bus.err_ovf !== 1'b1) begin
      errors++;
      $display("FAIL wrap_count: count=%0d ovf=%0b required 8/1", bus.count, bus.err_ovf);
    end
    read_run(0, 8, 16'h0004, "wrap_read");
  endtask

  task automatic test_simultaneous();
    // Shift 4 -> base=7, count=4 holding 8,9,A,B.
    bus.shift_en  = 1'b1;
    bus.shift_amt = 4'd4;
    tick();
    idle();
    checks++;
    if (bus.count !== 4'd4) begin
      errors++;
      $display("FAIL sim_pre_count: count=%0d required 4", bus.count);
    end
    bus.wr_en     = 1'b1;
    bus.din       = 16'h00C0;
    bus.shift_en  = 1'b1;
    bus.shift_amt = 4'd1;
    bus.rd_en     = 1'b1;
    bus.rd_offset = 3'd0;
    tick();
    idle();
    checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 16'h0008 || bus.count !== 4'd4) begin
      errors++;
      $display("FAIL sim_read: dout=%h dv=%0b count=%0d required 0008/1/4", bus.dout, bus.dout_valid, bus.count);
    end
    read_run(0, 3, 16'h0009, "sim_after");
    read_run(3, 1, 16'h00C0, "sim_written");
  endtask

  task automatic test_oob_underflow();
    bus.rd_en     = 1'b1;
    bus.rd_offset = 3'd4;
    tick();
    idle();
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.dout !== 16'h00C0) begin
      errors++;
      $display("FAIL oob_read: dout=%h dv=%0b required 00C0/0", bus.dout, bus.dout_valid);
    end
    bus.shift_en  = 1'b1;
    bus.shift_amt = 4'd2;
    tick();
    checks++;
    if (bus.count !== 4'd2 || bus.err_udf !== 1'b0) begin
      errors++;
      $display("FAIL udf_pre: count=%0d udf=%0b required 2/0", bus.count, bus.err_udf);
    end
    bus.shift_amt = 4'd6;
    tick();
    idle();
    checks++;
    if (bus.count !== 4'd0 || bus.err_udf !== 1'b1 || bus.err_ovf !== 1'b1) begin
      errors++;
      $display("FAIL udf_flag: count=%0d udf=%0b ovf=%0b required 0/1/1", bus.count, bus.err_udf, bus.err_ovf);
    end
  endtask

  task automatic test_clear();
    bus.wr_en = 1'b1;
    bus.din   = 16'h0D0D;
    tick();
    bus.clear     = 1'b1;
    bus.din       = 16'h0E0E;
    bus.rd_en     = 1'b1;
    bus.rd_offset = 3'd0;
    bus.shift_en  = 1'b1;
    bus.shift_amt = 4'd1;
    tick();
    idle();
    checks++;
    if (bus.count !== 4'd0 || bus.err_ovf !== 1'b0 || bus.err_udf !== 1'b0) begin
      errors++;
      $display("FAIL clear_state: count=%0d ovf=%0b udf=%0b required 0/0/0", bus.count, bus.err_ovf, bus.err_udf);
    end
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.dout !== 16'h00C0) begin
      errors++;
      $display("FAIL clear_dout: dout=%h dv=%0b required 00C0/0", bus.dout, bus.dout_valid);
    end
    // Pointers restart at entry 0 after clear.
    bus.wr_en = 1'b1;
    bus.din   = 16'h1111;
    tick();
    bus.wr_en = 1'b0;
    read_run(0, 1, 16'h1111, "clear_after");
  endtask

  task automatic test_async_reset();
    bus.wr_en = 1'b1;
    bus.din   = 16'h2222;
    tick();
    bus.wr_en = 1'b0;
    read_run(1, 1, 16'h2222, "ar_pre");
    bus.shift_en  = 1'b1;
    bus.shift_amt = 4'd5;
    tick();
    idle();
    bus.wr_en = 1'b1;
    bus.din   = 16'h3333;
    tick();
    checks++;
    if (bus.count !== 4'd1 || bus.err_udf !== 1'b1 || bus.dout !== 16'h2222) begin
      errors++;
      $display("FAIL ar_setup: count=%0d udf=%0b dout=%h required 1/1/2222", bus.count, bus.err_udf, bus.dout);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.count !== 4'd0 || bus.dout !== 16'h0 || bus.err_udf !== 1'b0 || bus.scratch_write_en !== 1'b1) begin
      errors++;
      $display("FAIL ar_immediate: count=%0d dout=%h udf=%0b swe=%0b required 0/0000/0/1",
               bus.count, bus.dout, bus.err_udf, bus.scratch_write_en);
    end
    tick();
    checks++;
    if (bus.count !== 4'd0 || bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_held: count=%0d dv=%0b required 0/0", bus.count, bus.dout_valid);
    end
    idle();
    rstn = 1'b1;
    tick();
    checks++;
    if (bus.count !== 4'd0 || bus.err_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ar_release: count=%0d ovf=%0b required 0/0", bus.count, bus.err_ovf);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill_read();
    test_overflow();
    test_wrap();
    test_simultaneous();
    test_oob_underflow();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
